// File: rtl/cnn_state_update.sv
// rtl/cnn_state_update.sv - forward-Euler CNN cell state integrator with PWL output
//
// Consumes each finished template sum (A*Y + B*U + I), steps the cell state
// x <- x + h*(sum - x) with h = 2^-STEP_SHIFT, applies the clamped-linear
// output y = clamp(x, -1.0, +1.0), counts iterations and reports run completion.
//
// Optional feature macro: CNN_CONVERGE_EN
//   defined   : a step with |delta| <= TOL ends the run with converged = 1
//   undefined : every run takes exactly MAX_ITER steps, converged stays 0
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle request: load x0 and begin a run (aborts a run)
//   x0         in   initial state, signed 2*WIDTH
//   sum_in     in   signed cell sum from the template-sum unit
//   sum_valid  in   finish flag of that unit (level; rising edge is accepted)
//   x_out      out  current state
//   y_out      out  current output, fed back to the Y inputs
//   y_valid    out  one-cycle pulse when x_out/y_out update from a step
//   iter       out  completed Euler steps in this run
//   busy       out  high while waiting for or applying a step
//   done       out  high once the run has finished
//   converged  out  run ended on the tolerance test (valid while done)

module cnn_state_update #(
    parameter int WIDTH      = 9,
    parameter int FRAC       = 8,
    parameter int STEP_SHIFT = 2,
    parameter int MAX_ITER   = 64,
    parameter int TOL        = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic signed [2*WIDTH-1:0]   x0,
    input  logic signed [2*WIDTH-1:0]   sum_in,
    input  logic                        sum_valid,
    output logic signed [2*WIDTH-1:0]   x_out,
    output logic signed [2*WIDTH-1:0]   y_out,
    output logic                        y_valid,
    output logic [7:0]                  iter,
    output logic                        busy,
    output logic                        done,
    output logic                        converged
);

    localparam int W2 = 2 * WIDTH;
    localparam int WD = W2 + 1;
    localparam logic [7:0] MAX_ITER_C = 8'(MAX_ITER);
    localparam logic signed [W2-1:0] PWL_ONE = W2'(1 << FRAC);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_UPDATE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 state_q;
    logic signed [W2-1:0]   x_q;
    logic signed [W2-1:0]   y_q;
    logic signed [W2-1:0]   sum_q;
    logic [7:0]             iter_q;
    logic                   y_valid_q;
    logic                   conv_q;
    logic                   sv_q;

    logic                   accept;
    logic signed [WD-1:0]   diff;
    logic signed [WD-1:0]   delta;
    logic signed [W2-1:0]   x_d;
    logic                   small_delta;
    logic                   last_step;

    function automatic logic signed [W2-1:0] pwl(input logic signed [W2-1:0] v);
        if (v > PWL_ONE) begin
            return PWL_ONE;
        end else if (v < -PWL_ONE) begin
            return -PWL_ONE;
        end else begin
            return v;
        end
    endfunction

    always_comb begin
        accept = sum_valid & ~sv_q;
        // One extra bit so sum - x cannot overflow; arithmetic shift floors.
        diff   = {sum_q[W2-1], sum_q} - {x_q[W2-1], x_q};
        delta  = diff >>> STEP_SHIFT;
        // x + h*(sum - x) lies between x and sum, so truncation is lossless.
        x_d    = x_q + W2'(delta);
`ifdef CNN_CONVERGE_EN
        small_delta = (delta <= WD'(TOL)) && (delta >= -(WD'(TOL)));
`else
        small_delta = 1'b0;
`endif
        last_step = ((iter_q + 8'd1) == MAX_ITER_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            sum_q     <= '0;
            iter_q    <= '0;
            y_valid_q <= 1'b0;
            conv_q    <= 1'b0;
            sv_q      <= 1'b0;
        end else begin
            sv_q      <= sum_valid;
            y_valid_q <= 1'b0;
            // start has priority over any accept or pending update.
            if (start) begin
                x_q     <= x0;
                y_q     <= pwl(x0);
                iter_q  <= '0;
                conv_q  <= 1'b0;
                state_q <= S_WAIT;
            end else begin
                case (state_q)
                    S_IDLE: begin
                    end
                    S_WAIT: begin
                        if (accept) begin
                            sum_q   <= sum_in;
                            state_q <= S_UPDATE;
                        end
                    end
                    S_UPDATE: begin
                        x_q       <= x_d;
                        y_q       <= pwl(x_d);
                        iter_q    <= iter_q + 8'd1;
                        y_valid_q <= 1'b1;
                        if (small_delta) begin
                            conv_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (last_step) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                    S_DONE: begin
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign x_out     = x_q;
    assign y_out     = y_q;
    assign y_valid   = y_valid_q;
    assign iter      = iter_q;
    assign busy      = (state_q == S_WAIT) || (state_q == S_UPDATE);
    assign done      = (state_q == S_DONE);
    assign converged = conv_q;

endmodule

// File: tb/tb_cnn_state_update.sv
// tb/tb_cnn_state_update.sv - directed self-checking bench for cnn_state_update

module tb_cnn_state_update;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic signed [17:0] x0;
    logic signed [17:0] sum_in;
    logic               sum_valid;
    logic signed [17:0] x_out;
    logic signed [17:0] y_out;
    logic               y_valid;
    logic [7:0]         iter;
    logic               busy;
    logic               done;
    logic               converged;

    int nchk  = 0;
    int nfail = 0;

    cnn_state_update #(
        .WIDTH(9), .FRAC(8), .STEP_SHIFT(2), .MAX_ITER(4), .TOL(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x0(x0),
        .sum_in(sum_in), .sum_valid(sum_valid),
        .x_out(x_out), .y_out(y_out), .y_valid(y_valid), .iter(iter),
        .busy(busy), .done(done), .converged(converged)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge; returns one falling edge later with start low.
    task automatic do_start(input logic signed [17:0] v);
        start = 1'b1;
        x0    = v;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a falling edge; returns after the accepting rising edge.
    task automatic do_accept(input logic signed [17:0] v);
        sum_in    = v;
        sum_valid = 1'b1;
        @(negedge clk);
        sum_valid = 1'b0;
    endtask

    task automatic test_reset;
        nchk++; if (x_out !== 18'sd0) begin nfail++; $display("FAIL reset_x: got %0d want 0", x_out); end
        nchk++; if (y_out !== 18'sd0) begin nfail++; $display("FAIL reset_y: got %0d want 0", y_out); end
        nchk++; if (y_valid !== 1'b0) begin nfail++; $display("FAIL reset_yvalid: got %b want 0", y_valid); end
        nchk++; if (iter !== 8'd0) begin nfail++; $display("FAIL reset_iter: got %0d want 0", iter); end
        nchk++; if ({busy, done, converged} !== 3'b000) begin nfail++; $display("FAIL reset_flags: got %b want 000", {busy, done, converged}); end
    endtask

    task automatic test_load_clamp;
        do_start(-18'sd300);
        nchk++; if (x_out !== -18'sd300) begin nfail++; $display("FAIL load_neg_x: got %0d want -300", x_out); end
        nchk++; if (y_out !== -18'sd256) begin nfail++; $display("FAIL load_neg_y: got %0d want -256", y_out); end
        nchk++; if (busy !== 1'b1) begin nfail++; $display("FAIL load_busy: got %b want 1", busy); end
        nchk++; if (y_valid !== 1'b0) begin nfail++; $display("FAIL load_no_pulse: got %b want 0", y_valid); end
        do_start(18'sd100);
        nchk++; if (y_out !== 18'sd100) begin nfail++; $display("FAIL load_pos_y: got %0d want 100", y_out); end
        nchk++; if (iter !== 8'd0) begin nfail++; $display("FAIL load_iter: got %0d want 0", iter); end
    endtask

    task automatic test_two_steps;
        do_start(18'sd0);
        do_accept(18'sd1024);
        nchk++; if (y_valid !== 1'b0) begin nfail++; $display("FAIL step1_early: got %b want 0", y_valid); end
        @(negedge clk);
        nchk++; if (y_valid !== 1'b1) begin nfail++; $display("FAIL step1_yvalid: got %b want 1", y_valid); end
        nchk++; if (x_out !== 18'sd256) begin nfail++; $display("FAIL step1_x: got %0d want 256", x_out); end
        nchk++; if (y_out !== 18'sd256) begin nfail++; $display("FAIL step1_y: got %0d want 256", y_out); end
        nchk++; if (iter !== 8'd1) begin nfail++; $display("FAIL step1_iter: got %0d want 1", iter); end
        @(negedge clk);
        nchk++; if (y_valid !== 1'b0) begin nfail++; $display("FAIL step1_pulse_width: got %b want 0", y_valid); end
        do_accept(18'sd1024);
        @(negedge clk);
        nchk++; if (x_out !== 18'sd448) begin nfail++; $display("FAIL step2_x: got %0d want 448", x_out); end
        nchk++; if (y_out !== 18'sd256) begin nfail++; $display("FAIL step2_y: got %0d want 256", y_out); end
        nchk++; if (iter !== 8'd2) begin nfail++; $display("FAIL step2_iter: got %0d want 2", iter); end
        nchk++; if (busy !== 1'b1) begin nfail++; $display("FAIL step2_busy: got %b want 1", busy); end
    endtask

    task automatic test_converge;
        do_start(18'sd0);
        do_accept(-18'sd3);
        @(negedge clk);
        nchk++; if (x_out !== -18'sd1) begin nfail++; $display("FAIL conv_x: got %0d want -1", x_out); end
        nchk++; if (y_out !== -18'sd1) begin nfail++; $display("FAIL conv_y: got %0d want -1", y_out); end
        nchk++; if (iter !== 8'd1) begin nfail++; $display("FAIL conv_iter: got %0d want 1", iter); end
`ifdef CNN_CONVERGE_EN
        nchk++; if ({busy, done, converged} !== 3'b011) begin nfail++; $display("FAIL conv_flags: got %b want 011", {busy, done, converged}); end
`else
        nchk++; if ({busy, done} !== 2'b10) begin nfail++; $display("FAIL noconv_running: got %b want 10", {busy, done}); end
        for (int i = 0; i < 3; i++) begin
            do_accept(-18'sd3);
            @(negedge clk);
        end
        nchk++; if (x_out !== -18'sd3) begin nfail++; $display("FAIL noconv_x: got %0d want -3", x_out); end
        nchk++; if (iter !== 8'd4) begin nfail++; $display("FAIL noconv_iter: got %0d want 4", iter); end
        nchk++; if ({busy, done, converged} !== 3'b010) begin nfail++; $display("FAIL noconv_flags: got %b want 010", {busy, done, converged}); end
`endif
    endtask

    task automatic test_max_iter;
        logic signed [17:0] sums [4];
        logic signed [17:0] xs   [4];
        logic signed [17:0] ys   [4];
        sums = '{18'sd20000, -18'sd20000, 18'sd20000, -18'sd20000};
        xs   = '{18'sd5000, -18'sd1250, 18'sd4062, -18'sd1954};
        ys   = '{18'sd256, -18'sd256, 18'sd256, -18'sd256};
        do_start(18'sd0);
        for (int i = 0; i < 4; i++) begin
            do_accept(sums[i]);
            @(negedge clk);
            nchk++; if (x_out !== xs[i]) begin nfail++; $display("FAIL max_x%0d: got %0d want %0d", i, x_out, xs[i]); end
            nchk++; if (y_out !== ys[i]) begin nfail++; $display("FAIL max_y%0d: got %0d want %0d", i, y_out, ys[i]); end
        end
        nchk++; if ({busy, done, converged} !== 3'b010) begin nfail++; $display("FAIL max_flags: got %b want 010", {busy, done, converged}); end
        nchk++; if (iter !== 8'd4) begin nfail++; $display("FAIL max_iter: got %0d want 4", iter); end
        do_accept(18'sd500);
        @(negedge clk);
        nchk++; if (y_valid !== 1'b0 || x_out !== -18'sd1954) begin nfail++; $display("FAIL done_hold: got yv=%b x=%0d want yv=0 x=-1954", y_valid, x_out); end
        do_start(18'sd77);
        do_accept(18'sd1024);
        @(negedge clk);
        nchk++; if (iter !== 8'd1) begin nfail++; $display("FAIL restart_iter: got %0d want 1", iter); end
        do_start(-18'sd50);
        nchk++; if (x_out !== -18'sd50 || y_out !== -18'sd50) begin nfail++; $display("FAIL abort_xy: got %0d/%0d want -50/-50", x_out, y_out); end
        nchk++; if (iter !== 8'd0 || busy !== 1'b1) begin nfail++; $display("FAIL abort_iter: got iter=%0d busy=%b want 0/1", iter, busy); end
    endtask

    task automatic test_start_wins;
        start     = 1'b1;
        x0        = 18'sd10;
        sum_in    = 18'sd1024;
        sum_valid = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        sum_valid = 1'b0;
        nchk++; if (x_out !== 18'sd10 || iter !== 8'd0) begin nfail++; $display("FAIL start_wins_load: got x=%0d iter=%0d want 10/0", x_out, iter); end
        @(negedge clk);
        @(negedge clk);
        nchk++; if (y_valid !== 1'b0 || x_out !== 18'sd10) begin nfail++; $display("FAIL start_wins_noupd: got yv=%b x=%0d want 0/10", y_valid, x_out); end
    endtask

    task automatic test_held_level;
        int cnt;
        do_start(18'sd0);
        sum_in    = 18'sd1024;
        sum_valid = 1'b1;
        cnt = 0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (y_valid) cnt++;
        end
        sum_valid = 1'b0;
        nchk++; if (cnt !== 1) begin nfail++; $display("FAIL held_pulses: got %0d want 1", cnt); end
        nchk++; if (x_out !== 18'sd256 || iter !== 8'd1) begin nfail++; $display("FAIL held_state: got x=%0d iter=%0d want 256/1", x_out, iter); end
        sum_valid = 1'b1;
        do_start(18'sd100);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (y_valid) cnt++;
        end
        nchk++; if (cnt !== 0 || iter !== 8'd0) begin nfail++; $display("FAIL prehigh_ignored: got pulses=%0d iter=%0d want 0/0", cnt, iter); end
        sum_valid = 1'b0;
        @(negedge clk);
        do_accept(18'sd1024);
        @(negedge clk);
        nchk++; if (y_valid !== 1'b1 || x_out !== 18'sd331 || y_out !== 18'sd256) begin nfail++; $display("FAIL prehigh_step: got yv=%b x=%0d y=%0d want 1/331/256", y_valid, x_out, y_out); end
    endtask

    task automatic test_reset_mid_update;
        do_start(18'sd50);
        do_accept(18'sd1024);
        rst_n = 1'b0;
        #1;
        nchk++; if (x_out !== 18'sd0 || y_out !== 18'sd0) begin nfail++; $display("FAIL rst_mid_xy: got %0d/%0d want 0/0", x_out, y_out); end
        nchk++; if ({y_valid, busy, done, converged} !== 4'b0000 || iter !== 8'd0) begin nfail++; $display("FAIL rst_mid_flags: got %b iter=%0d want 0000/0", {y_valid, busy, done, converged}, iter); end
        @(negedge clk);
        nchk++; if (y_valid !== 1'b0 || x_out !== 18'sd0) begin nfail++; $display("FAIL rst_mid_hold: got yv=%b x=%0d want 0/0", y_valid, x_out); end
        rst_n = 1'b1;
        @(negedge clk);
        nchk++; if (busy !== 1'b0 || done !== 1'b0) begin nfail++; $display("FAIL rst_idle: got busy=%b done=%b want 0/0", busy, done); end
        do_start(18'sd0);
        do_accept(18'sd1024);
        @(negedge clk);
        nchk++; if (x_out !== 18'sd256 || iter !== 8'd1 || y_valid !== 1'b1) begin nfail++; $display("FAIL rst_rerun: got x=%0d iter=%0d yv=%b want 256/1/1", x_out, iter, y_valid); end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        x0        = '0;
        sum_in    = '0;
        sum_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_load_clamp();
        test_two_steps();
        test_converge();
        test_max_iter();
        test_start_wins();
        test_held_level();
        test_reset_mid_update();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
